sram_array_1rw_ext: RTL and testbench

SRAM_ARRAY_1RW_EXT -- requirements
Module: sram_array_1rw_ext

---
 rtl/sram_array_1rw_ext.sv | 160 ++++++++++++++++
 tb/tb_sram_array_1rw_ext.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_array_1rw_ext.sv
// Single-port synchronous SRAM wrapper with per-lane write mask, optional output register
// and a post-reset clearing sequence that holds off requests until the array is ready.
module sram_array_1rw_ext #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 137,
  parameter int MASK_GRAN  = 137,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1,
  localparam int DEPTH = 2 ** ADDR_WIDTH,
  localparam int MW    = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst_n,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [MW-1:0]         RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic                  RW0_ready,
  output logic                  RW0_rvalid,
  output logic [DATA_WIDTH-1:0] RW0_rdata
);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   ready_q;

  logic                   req_rd;
  logic                   req_wr;

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [MW-1:0]          mem_wmask;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;

  // Requests only count once the registered ready flag is up.
  assign req_rd = RW0_en && ready_q && !RW0_wmode;
  assign req_wr = RW0_en && ready_q &&  RW0_wmode;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (INIT_ZERO == 0 || cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from the pre-edge values.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_READY);
    end
  end

  assign RW0_ready = ready_q;

  // Clearing writes own the port during INIT; user writes can only happen once ready.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = RW0_addr;
    mem_wmask = RW0_wmask;
    mem_wdata = RW0_wdata;
    if (state_q == ST_INIT && INIT_ZERO != 0) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wmask = '1;
      mem_wdata = '0;
    end else if (req_wr) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the storage array has no reset branch; it is a RAM macro, and clearing it is the
  // job of the INIT sequence, not of the reset network.
  always_ff @(posedge RW0_clk) begin
    if (mem_we) begin
      for (int k = 0; k < MW; k++) begin
        if (mem_wmask[k]) begin
          mem[mem_waddr][k*MASK_GRAN +: MASK_GRAN] <= mem_wdata[k*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // First read stage: the word is captured at the accepting edge, so later writes cannot
  // disturb a read already in flight.
  always_comb begin
    s1_valid_d = req_rd;
    s1_data_d  = s1_data_q;
    if (req_rd) begin
      s1_data_d = mem[RW0_addr];
    end
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_q;
        end
      end

      always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign RW0_rvalid = s2_valid_q;
      assign RW0_rdata  = s2_data_q;
    end else begin : g_no_out_reg
      assign RW0_rvalid = s1_valid_q;
      assign RW0_rdata  = s1_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_array_1rw_ext.sv
// Directed bench: a latency-2 clearing instance driven from a vector table plus reset
// sequences, and a latency-1 non-clearing instance driven by a short hand sequence.
module tb_sram_array_1rw_ext;

  logic clk;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Instance A: OUT_REG=1, INIT_ZERO=1
  logic        a_rst_n, a_en, a_wmode, a_ready, a_rvalid;
  logic [3:0]  a_addr;
  logic [1:0]  a_wmask;
  logic [15:0] a_wdata, a_rdata;

  // Instance B: OUT_REG=0, INIT_ZERO=0
  logic        b_rst_n, b_en, b_wmode, b_ready, b_rvalid;
  logic [3:0]  b_addr;
  logic [1:0]  b_wmask;
  logic [15:0] b_wdata, b_rdata;

  sram_array_1rw_ext #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .MASK_GRAN(8), .OUT_REG(1), .INIT_ZERO(1)
  ) u_dut_a (
    .RW0_clk(clk), .RW0_rst_n(a_rst_n), .RW0_addr(a_addr), .RW0_en(a_en),
    .RW0_wmode(a_wmode), .RW0_wmask(a_wmask), .RW0_wdata(a_wdata),
    .RW0_ready(a_ready), .RW0_rvalid(a_rvalid), .RW0_rdata(a_rdata)
  );

  sram_array_1rw_ext #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .MASK_GRAN(8), .OUT_REG(0), .INIT_ZERO(0)
  ) u_dut_b (
    .RW0_clk(clk), .RW0_rst_n(b_rst_n), .RW0_addr(b_addr), .RW0_en(b_en),
    .RW0_wmode(b_wmode), .RW0_wmask(b_wmask), .RW0_wdata(b_wdata),
    .RW0_ready(b_ready), .RW0_rvalid(b_rvalid), .RW0_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wmode;
    logic [3:0]  addr;
    logic [1:0]  wmask;
    logic [15:0] wdata;
    logic        exp_rv;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic en, input logic wmode, input logic [3:0] addr,
                              input logic [1:0] wmask, input logic [15:0] wdata,
                              input logic exp_rv, input logic [15:0] exp_rd);
    vec_t v;
    v.en = en; v.wmode = wmode; v.addr = addr; v.wmask = wmask; v.wdata = wdata;
    v.exp_rv = exp_rv; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic wmode, input logic [3:0] addr,
                         input logic [1:0] wmask, input logic [15:0] wdata);
    a_en = en; a_wmode = wmode; a_addr = addr; a_wmask = wmask; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic en, input logic wmode, input logic [3:0] addr,
                         input logic [1:0] wmask, input logic [15:0] wdata);
    b_en = en; b_wmode = wmode; b_addr = addr; b_wmask = wmask; b_wdata = wdata;
  endtask

  // Counts edges from reset release until ready rises, with en=1 reads pulsed throughout.
  task automatic wait_init(input string tag);
    int rose;
    bit saw_rv;
    rose   = -1;
    saw_rv = 1'b0;
    for (int c = 1; c <= 40 && rose < 0; c++) begin
      drive_a(1'b1, 1'b0, 4'(c), 2'b11, 16'hFFFF);
      tick();
      if (a_rvalid) saw_rv = 1'b1;
      if (a_ready) rose = c;
    end
    drive_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
    check({tag, "_init_cycles"}, rose, 16);
    check({tag, "_init_no_rvalid"}, {31'd0, saw_rv}, 0);
  endtask

  // Back-to-back reads of every address; each result must be zero, two cycles later.
  task automatic read_all_zero(input string tag);
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive_a(1'b1, 1'b0, 4'(c), 2'b00, 16'h0000);
      else        drive_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
      tick();
      if (c >= 1 && c <= 16) begin
        check($sformatf("%s_rv_addr%0d", tag, c - 1), {31'd0, a_rvalid}, 1);
        check($sformatf("%s_rd_addr%0d", tag, c - 1), {16'd0, a_rdata}, 0);
      end else begin
        check($sformatf("%s_rv_idle%0d", tag, c), {31'd0, a_rvalid}, 0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rd_order [4];
    logic [15:0] b_vals   [4];

    clk = 1'b0;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
    drive_b(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);

    // Table: per cycle inputs and the outputs seen just after that cycle's edge.
    vecs[0]  = mk(1, 1, 4'd3, 2'b11, 16'hABCD, 0, 16'h0000);
    vecs[1]  = mk(1, 1, 4'd3, 2'b01, 16'h1234, 0, 16'h0000);
    vecs[2]  = mk(1, 0, 4'd3, 2'b00, 16'h0000, 0, 16'h0000);
    vecs[3]  = mk(1, 1, 4'd5, 2'b11, 16'h1111, 1, 16'hAB34);
    vecs[4]  = mk(1, 0, 4'd5, 2'b00, 16'h0000, 0, 16'hAB34);
    vecs[5]  = mk(1, 1, 4'd5, 2'b11, 16'h2222, 1, 16'h1111);
    vecs[6]  = mk(1, 0, 4'd5, 2'b00, 16'h0000, 0, 16'h1111);
    vecs[7]  = mk(0, 1, 4'd5, 2'b11, 16'hDEAD, 1, 16'h2222);
    vecs[8]  = mk(1, 1, 4'd7, 2'b10, 16'hC3FF, 0, 16'h2222);
    vecs[9]  = mk(1, 1, 4'd7, 2'b00, 16'hFFFF, 0, 16'h2222);
    vecs[10] = mk(1, 0, 4'd7, 2'b00, 16'h0000, 0, 16'h2222);
    vecs[11] = mk(1, 0, 4'd3, 2'b00, 16'h0000, 1, 16'hC300);
    vecs[12] = mk(1, 0, 4'd5, 2'b00, 16'h0000, 1, 16'hAB34);
    vecs[13] = mk(1, 1, 4'd3, 2'b11, 16'h5555, 1, 16'h2222);
    vecs[14] = mk(1, 1, 4'd5, 2'b11, 16'h6666, 0, 16'h2222);
    vecs[15] = mk(0, 0, 4'd0, 2'b00, 16'h0000, 0, 16'h2222);
    vecs[16] = mk(1, 0, 4'd3, 2'b00, 16'h0000, 0, 16'h2222);
    vecs[17] = mk(0, 0, 4'd0, 2'b00, 16'h0000, 1, 16'h5555);
    vecs[18] = mk(0, 0, 4'd0, 2'b00, 16'h0000, 0, 16'h5555);

    // Reset state of A
    tick();
    tick();
    check("a_rst_ready",  {31'd0, a_ready},  0);
    check("a_rst_rvalid", {31'd0, a_rvalid}, 0);
    check("a_rst_rdata",  {16'd0, a_rdata},  0);

    a_rst_n = 1'b1;
    wait_init("first");
    read_all_zero("first");

    for (int i = 0; i < 19; i++) begin
      drive_a(vecs[i].en, vecs[i].wmode, vecs[i].addr, vecs[i].wmask, vecs[i].wdata);
      tick();
      check($sformatf("vec%0d_rvalid", i), {31'd0, a_rvalid}, {31'd0, vecs[i].exp_rv});
      check($sformatf("vec%0d_rdata", i),  {16'd0, a_rdata},  {16'd0, vecs[i].exp_rd});
    end

    // Reset while a read of addr 3 is in flight: it must be discarded.
    drive_a(1'b1, 1'b0, 4'd3, 2'b00, 16'h0000);
    tick();
    drive_a(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("rdy_rst_ready",  {31'd0, a_ready},  0);
    check("rdy_rst_rvalid", {31'd0, a_rvalid}, 0);
    check("rdy_rst_rdata",  {16'd0, a_rdata},  0);
    tick();
    check("rdy_rst_inflight_dropped", {31'd0, a_rvalid}, 0);
    a_rst_n = 1'b1;

    // Reset again at INIT cycle 7: clearing must restart and take a full 16 cycles.
    for (int c = 0; c < 7; c++) tick();
    check("init7_not_ready", {31'd0, a_ready}, 0);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("init7_rst_ready",  {31'd0, a_ready},  0);
    check("init7_rst_rvalid", {31'd0, a_rvalid}, 0);
    check("init7_rst_rdata",  {16'd0, a_rdata},  0);
    tick();
    a_rst_n = 1'b1;
    wait_init("restart");
    read_all_zero("restart");

    // Instance B: no clearing, latency 1.
    check("b_rst_ready",  {31'd0, b_ready},  0);
    check("b_rst_rvalid", {31'd0, b_rvalid}, 0);
    check("b_rst_rdata",  {16'd0, b_rdata},  0);
    b_rst_n = 1'b1;
    #1;
    check("b_released_not_ready", {31'd0, b_ready}, 0);
    tick();
    check("b_ready_after_one", {31'd0, b_ready}, 1);

    b_vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 1'b1, 4'(i), 2'b11, b_vals[i]);
      tick();
      check($sformatf("b_wr%0d_no_rvalid", i), {31'd0, b_rvalid}, 0);
    end

    rd_order = '{4'd2, 4'd0, 4'd3, 4'd1};
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 1'b0, rd_order[i], 2'b00, 16'h0000);
      tick();
      check($sformatf("b_rd%0d_rvalid", i), {31'd0, b_rvalid}, 1);
      check($sformatf("b_rd%0d_rdata", i),  {16'd0, b_rdata},  {16'd0, b_vals[rd_order[i]]});
    end

    drive_b(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("b_hold%0d_rvalid", i), {31'd0, b_rvalid}, 0);
      check($sformatf("b_hold%0d_rdata", i),  {16'd0, b_rdata},  16'h2222);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
